// File: rtl/mul54_pkg.sv
// mul54_pkg
//   Shared widths, FSM state encoding and the partial-product shift helper
//   used by the sequential 54x54 multiplier and its 27x27 sub-multiplier.
package mul54_pkg;

    localparam int HALF_W = 27;
    localparam int OP_W   = 54;
    localparam int PROD_W = 108;
    localparam int NSTEP  = 4;

    localparam logic [1:0] LAST_STEP = 2'(NSTEP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Left shift applied to the partial product of each step:
    // step0 al*bl, step1 al*bh, step2 ah*bl, step3 ah*bh.
    function automatic int unsigned pp_shift(input logic [1:0] step);
        case (step)
            2'd0:    return 0;
            2'd1:    return HALF_W;
            2'd2:    return HALF_W;
            default: return 2 * HALF_W;
        endcase
    endfunction

endpackage

// File: rtl/mul54_seq_mul27.sv
// mul54_seq_mul27
//   Combinational 27x27 unsigned multiplier with a full 54-bit result.
//   Ports:
//     Out  output 54  A*B
//     A    input  27  unsigned operand
//     B    input  27  unsigned operand
module mul54_seq_mul27
    import mul54_pkg::*;
(
    output logic [2*HALF_W-1:0] Out,
    input  logic [HALF_W-1:0]   A,
    input  logic [HALF_W-1:0]   B
);

    // Zero-extend both operands so the product is computed at full width.
    assign Out = {{HALF_W{1'b0}}, A} * {{HALF_W{1'b0}}, B};

endmodule

// File: rtl/mul54_seq.sv
// mul54_seq
//   Sequential 54x54 unsigned multiplier. One 27x27 multiplier is time-shared
//   over four MUL cycles; the shifted partial products are summed into a
//   108-bit accumulator and the result is registered into product.
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready
//   are both high. valid must hold its payload until that edge; ready may
//   depend on state only (never combinationally on valid).
//
//   Ports:
//     clk        input   1    clock, rising edge
//     rst_n      input   1    synchronous active-low reset
//     in_valid   input   1    a/b operand pair valid
//     in_ready   output  1    operand pair accepted this cycle (IDLE only)
//     a, b       input   54   unsigned operands
//     out_valid  output  1    product holds a completed result (DONE)
//     out_ready  input   1    consumer takes the product this cycle
//     product    output  108  registered a*b, held until the next DONE
//     busy       output  1    high in MUL
//     dbg_state  output  2    current FSM state
//     dbg_step   output  2    current step counter
module mul54_seq
    import mul54_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy,
    output state_t            dbg_state,
    output logic [1:0]        dbg_step
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_step;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [PROD_W-1:0]   r_acc;
    logic [PROD_W-1:0]   r_product;

    logic                w_accept;
    logic                w_last;
    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_busy;

    logic [HALF_W-1:0]   w_mul_a;
    logic [HALF_W-1:0]   w_mul_b;
    logic [OP_W-1:0]     w_pp;
    logic [PROD_W-1:0]   w_pp_sh;
    logic [PROD_W-1:0]   w_acc_sum;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = MUL;
                end
            end
            MUL: begin
                w_busy = 1'b1;
                if (r_step == LAST_STEP) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign product   = r_product;
    assign dbg_state = r_state;
    assign dbg_step  = r_step;

    // ------------------------------------------------------------------
    // Partial-product selection: the multiplier sees zeros outside MUL so
    // it does not toggle while idle or holding a result.
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        if (r_state == MUL) begin
            case (r_step)
                2'd0: begin
                    w_mul_a = r_a[HALF_W-1:0];
                    w_mul_b = r_b[HALF_W-1:0];
                end
                2'd1: begin
                    w_mul_a = r_a[HALF_W-1:0];
                    w_mul_b = r_b[OP_W-1:HALF_W];
                end
                2'd2: begin
                    w_mul_a = r_a[OP_W-1:HALF_W];
                    w_mul_b = r_b[HALF_W-1:0];
                end
                default: begin
                    w_mul_a = r_a[OP_W-1:HALF_W];
                    w_mul_b = r_b[OP_W-1:HALF_W];
                end
            endcase
        end
    end

    mul54_seq_mul27 u_mul27 (
        .Out (w_pp),
        .A   (w_mul_a),
        .B   (w_mul_b)
    );

    // Full sum is bounded by (2^54-1)^2 < 2^108, so no carry-out is needed.
    assign w_pp_sh   = {{(PROD_W-OP_W){1'b0}}, w_pp} << pp_shift(r_step);
    assign w_acc_sum = r_acc + w_pp_sh;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_step <= '0;
        end else if (r_state == MUL) begin
            r_acc  <= w_acc_sum;
            r_step <= r_step + 2'd1;
            // The last step's sum goes straight to product so it is
            // valid on the same edge the FSM enters DONE.
            if (w_last) begin
                r_product <= w_acc_sum;
            end
        end
    end

endmodule

// File: doc/mul54_seq.md
MUL54_SEQ -- requirements
Module: mul54_seq

Interface
REQ-001 Parameters: none; all widths come from the shared package (HALF_W=27, OP_W=54, PROD_W=108, NSTEP=4).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  operand pair a/b is valid.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 a  input  54  unsigned multiplicand.
REQ-007 b  input  54  unsigned multiplier.
REQ-008 out_valid  output  1  product holds a completed result.
REQ-009 out_ready  input  1  consumer accepts the product this cycle.
REQ-010 product  output  108  unsigned a*b, registered.
REQ-011 busy  output  1  high in MUL state.

Function
REQ-012 The block SHALL compute a full 54x54 unsigned product by time-sharing one 27x27 multiplier over 4 steps.
REQ-013 Operand split SHALL be a = ah*2^27 + al and b = bh*2^27 + bl, with each half 27 bits unsigned.
REQ-014 State machine SHALL have states IDLE, MUL and DONE, plus a 2-bit step counter.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, latch a and b, clear acc, set step=0, and go to MUL.
REQ-016 MUL partial products SHALL be issued in fixed order: step0 al*bl<<0, step1 al*bh<<27, step2 ah*bl<<27, step3 ah*bh<<54.
REQ-017 Each MUL cycle SHALL add the shifted 54-bit partial product into a 108-bit accumulator.
REQ-018 The accumulator SHALL never overflow, since the sum is at most (2^54-1)^2; no carry-out is kept.
REQ-019 After step3, the FSM SHALL go to DONE, and product SHALL equal the accumulator.
REQ-020 Latency: if accepted at edge T, out_valid SHALL rise at edge T+4 (4 MUL cycles), with no gaps.
REQ-021 DONE: out_valid=1; product and out_valid SHALL stay stable until out_valid&&out_ready, then the FSM returns to IDLE.
REQ-022 in_ready SHALL be 0 in MUL and DONE; in_valid is ignored there, and latched operands do not change.
REQ-023 There is no overlap: a new operand SHALL be accepted no earlier than the cycle after the output handshake.
REQ-024 Multiplier inputs SHALL be driven to zero outside MUL.
REQ-025 product SHALL keep its last value after the handshake, until the next DONE.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force: state=IDLE, step=0, acc=0, product=0, latched a/b=0, out_valid=0, busy=0; in_ready=1 after release.
REQ-027 Reset in MUL or DONE SHALL abort the operation with no output handshake, and the partial result SHALL be discarded.
REQ-028 Reset SHALL have priority over all handshakes in the same cycle.

Structure
REQ-029 Package mul54_pkg SHALL hold the state enum (IDLE, MUL, DONE) and the constants HALF_W, OP_W, PROD_W and NSTEP.
REQ-030 One sub-module SHALL exist: the team's existing combinational multiplier (27x27 to 54, ports Out, A, B), instantiated once.
REQ-031 No other arithmetic multiplier SHALL be inferred; partial-product selection is a mux on step.

Verification
REQ-032 a=0, b=0 accepted -> out_valid at T+4, product=0.
REQ-033 a=b=2^54-1 -> product=2^108-2^55+1, so all four steps carry maximum values.
REQ-034 a=2^27, b=2^27 -> product=2^54 (only step3 nonzero); a=5, b=7 -> product=35 (only step0 nonzero).
REQ-035 Backpressure: out_ready held 0 for 3 cycles after out_valid -> product and out_valid stable, in_ready=0, and a second in_valid is ignored.
REQ-036 rst_n=0 during MUL step2 -> next cycle in_ready=1, out_valid=0, product=0; a new pair (a=3, b=4) then yields 12 at T+4.
REQ-037 Back-to-back: pair A=0x3FFFFFF_FFFFFFF, B=1, then immediately a=1, b=2 -> products match a*b, and the second acceptance occurs exactly 1 cycle after the first output handshake.
